// File: rtl/sdram_req_scheduler.sv
// sdram_req_scheduler
//   Fixed-priority scheduler sharing the single SDRAM controller port between
//   four requesters (bit 0 CD_WR, bit 1 CROM, bit 2 SROM, bit 3 M68K; bit 0 is
//   the highest priority). Request edges are latched into pending flags. The
//   winner gets a one-hot GRANT, which steers the address/data mux, and a
//   one-cycle RD or WR start pulse. GRANT is held until the controller reports
//   completion, and then the owner receives a one-cycle DONE strobe.
//
// Ports
//   clk_sys         system clock
//   nRESET          asynchronous active-low reset
//   REQ[NREQ]       request levels; a rising edge is a request
//   REQ_EN[NREQ]    per-requester enable, sampled when the requester wins
//   sdram_ready     controller idle/complete level
//   SDRAM_RD_PULSE  one-cycle read start
//   SDRAM_WR_PULSE  one-cycle write start
//   SDRAM_RD_TYPE   1 = burst read; set with the start pulse, held until release
//   GRANT[NREQ]     one-hot port owner, zero when idle
//   DONE[NREQ]      one-cycle completion strobe to the owner
//   PENDING[NREQ]   latched requests that have not been served yet
//   TIMEOUT_ERR     one-cycle pulse when an access is force-released
//   BUSY            scheduler is not idle
//
// Build option
//   SDRAM_SCHED_STARVE_GUARD_EN : when defined, a requester that has been
//   passed over STARVE_MAX times wins over strict priority.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no owner; pick the next pending requester when the port is ready
// S_WAIT_LO | start pulse issued; waiting for the controller to drop ready
// S_WAIT_HI | controller busy; waiting for ready to return
// S_RELEASE | DONE issued; GRANT drops here so the mux settles for one cycle

module sdram_req_scheduler #(
   parameter int              NREQ       = 4,
   parameter logic [NREQ-1:0] WRITE_MASK = NREQ'(4'b0001),
   parameter logic [NREQ-1:0] BURST_MASK = NREQ'(4'b0010),
   parameter int              TIMEOUT    = 255,
   parameter int              STARVE_MAX = 4
) (
   input  logic            clk_sys,
   input  logic            nRESET,
   input  logic [NREQ-1:0] REQ,
   input  logic [NREQ-1:0] REQ_EN,
   input  logic            sdram_ready,
   output logic            SDRAM_RD_PULSE,
   output logic            SDRAM_WR_PULSE,
   output logic            SDRAM_RD_TYPE,
   output logic [NREQ-1:0] GRANT,
   output logic [NREQ-1:0] DONE,
   output logic [NREQ-1:0] PENDING,
   output logic            TIMEOUT_ERR,
   output logic            BUSY
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_LO, S_WAIT_HI, S_RELEASE} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] req_prev;
   logic [NREQ-1:0] req_edge;
   logic [NREQ-1:0] pending_q, pending_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [NREQ-1:0] pend_clr;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] sel_oh;
   logic            rd_pulse_q, rd_pulse_d;
   logic            wr_pulse_q, wr_pulse_d;
   logic            rd_type_q, rd_type_d;
   logic            to_err_q, to_err_d;
   logic [TW-1:0]   tmr_q, tmr_d;

   assign req_edge = REQ & ~req_prev;

`ifdef SDRAM_SCHED_STARVE_GUARD_EN
   localparam int AW = $clog2(STARVE_MAX + 1);

   logic [AW-1:0]   age_q [NREQ];
   logic [NREQ-1:0] starve;
   logic            grant_go;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         starve[i] = pending_q[i] && (age_q[i] == AW'(STARVE_MAX));
      end
   end

   assign cand     = (|starve) ? starve : pending_q;
   assign grant_go = (state_q == S_IDLE) && sdram_ready && (|(sel_oh & REQ_EN));

   // Age counts grants handed to someone else while this requester waits.
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         for (int i = 0; i < NREQ; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pending_d[i] || (grant_go && sel_oh[i])) begin
               age_q[i] <= '0;
            end else if (grant_go && pending_q[i] && (age_q[i] != AW'(STARVE_MAX))) begin
               age_q[i] <= age_q[i] + AW'(1);
            end
         end
      end
   end
`else
   assign cand = pending_q;
`endif

   // Lowest-index candidate wins.
   always_comb begin
      sel_oh = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
   end

   // One timer spans both wait states; reaching terminal count forces release.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      done_d     = '0;
      rd_pulse_d = 1'b0;
      wr_pulse_d = 1'b0;
      rd_type_d  = rd_type_q;
      to_err_d   = 1'b0;
      tmr_d      = tmr_q;
      pend_clr   = '0;
      case (state_q)
         S_IDLE: begin
            if (sdram_ready && (|pending_q)) begin
               pend_clr = sel_oh;
               // A disabled winner is dropped without an access.
               if (|(sel_oh & REQ_EN)) begin
                  grant_d    = sel_oh;
                  wr_pulse_d = |(sel_oh & WRITE_MASK);
                  rd_pulse_d = ~(|(sel_oh & WRITE_MASK));
                  rd_type_d  = |(sel_oh & BURST_MASK);
                  tmr_d      = TW'(TIMEOUT);
                  state_d    = S_WAIT_LO;
               end
            end
         end
         S_WAIT_LO: begin
            if (tmr_q == TW'(1)) begin
               done_d   = grant_q;
               to_err_d = 1'b1;
               state_d  = S_RELEASE;
            end else begin
               tmr_d = tmr_q - TW'(1);
               if (!sdram_ready) state_d = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (sdram_ready) begin
               done_d  = grant_q;
               state_d = S_RELEASE;
            end else if (tmr_q == TW'(1)) begin
               done_d   = grant_q;
               to_err_d = 1'b1;
               state_d  = S_RELEASE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_RELEASE: begin
            grant_d   = '0;
            rd_type_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A fresh edge on the bit being cleared re-arms it for a second access.
      pending_d = (pending_q & ~pend_clr) | req_edge;
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= S_IDLE;
         req_prev   <= '0;
         pending_q  <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         rd_pulse_q <= 1'b0;
         wr_pulse_q <= 1'b0;
         rd_type_q  <= 1'b0;
         to_err_q   <= 1'b0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_prev   <= REQ;
         pending_q  <= pending_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         rd_pulse_q <= rd_pulse_d;
         wr_pulse_q <= wr_pulse_d;
         rd_type_q  <= rd_type_d;
         to_err_q   <= to_err_d;
         tmr_q      <= tmr_d;
      end
   end

   assign SDRAM_RD_PULSE = rd_pulse_q;
   assign SDRAM_WR_PULSE = wr_pulse_q;
   assign SDRAM_RD_TYPE  = rd_type_q;
   assign GRANT          = grant_q;
   assign DONE           = done_q;
   assign PENDING        = pending_q;
   assign TIMEOUT_ERR    = to_err_q;
   assign BUSY           = (state_q != S_IDLE);

endmodule

// File: doc/sdram_req_scheduler.md
Name: sdram_req_scheduler

Overview:
- Fixed-priority scheduler that shares the single SDRAM controller port between four requesters: CD/DMA write, C ROM burst read, S ROM read and 68k/DMA read.
- Latches request edges into pending flags and issues one-cycle read/write pulses to the controller.
- Holds a one-hot grant (which drives the address/data mux) until the controller signals completion, then returns a per-requester done strobe.
- Replaces ad-hoc REQ/RUN flag logic scattered through the SDRAM mux.

Parameters:
- NREQ, 4, number of requesters; bit order is priority, bit 0 highest.
- WRITE_MASK, 4'b0001, requesters whose access is a write (WR pulse instead of RD pulse).
- BURST_MASK, 4'b0010, requesters whose read is a burst (SDRAM_RD_TYPE=1).
- TIMEOUT, 255, maximum clocks to wait for completion before forced release.
- STARVE_MAX, 4, grants a pending requester may be passed over before it is promoted (optional feature only).

Ports:
- clk_sys  in  1  system clock.
- nRESET  in  1  asynchronous active-low reset.
- REQ  in  NREQ  request level per requester; the rising edge is the request (bit0 CD_WR, bit1 CROM, bit2 SROM, bit3 M68K).
- REQ_EN  in  NREQ  enable per requester (SPR_EN/FIX_EN style); checked at grant time.
- sdram_ready  in  1  controller idle/complete level.
- SDRAM_RD_PULSE  out  1  one-cycle read start.
- SDRAM_WR_PULSE  out  1  one-cycle write start.
- SDRAM_RD_TYPE  out  1  1 = burst read, 0 = single; valid with RD pulse and held through the access.
- GRANT  out  NREQ  one-hot owner of the port; all-zero when idle.
- DONE  out  NREQ  one-cycle strobe to the owner when its access completes; data is valid on sdram_dout that cycle.
- PENDING  out  NREQ  latched, not-yet-served requests.
- TIMEOUT_ERR  out  1  one-cycle pulse on forced release.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset: async on nRESET low. All outputs 0, all internal state 0, state=IDLE, REQ edge history = 0. A reset mid-access abandons the access with no DONE.
- Edge detect: req_prev is a registered copy of REQ. An edge is REQ & ~req_prev and sets PENDING[i] on the next clock.
  - An edge on an already-pending bit merges (single access).
  - An edge on the currently granted bit sets PENDING again, giving a second access after the first.
- State machine:
  - IDLE: when sdram_ready=1 and PENDING!=0, pick the lowest-index pending bit i.
    - If REQ_EN[i]=0: clear PENDING[i], no access, stay IDLE. Only one bit is evaluated per cycle.
    - Otherwise: clear PENDING[i], set GRANT=onehot(i), pulse WR (if WRITE_MASK[i]) or RD, set SDRAM_RD_TYPE=BURST_MASK[i], go to WAIT_LOW.
  - WAIT_LOW: wait for sdram_ready=0, then go to WAIT_HIGH. If sdram_ready stays 1 for TIMEOUT clocks, force release.
  - WAIT_HIGH: on a sampled 0->1 of sdram_ready, pulse DONE[i] and go to RELEASE.
  - RELEASE: GRANT=0, return to IDLE. This gives one dead cycle so the address mux settles before the next pulse.
- Latency: REQ seen high at clock edge 0 → PENDING at 1 → pulse + GRANT at 2 (idle, ready). Back-to-back accesses start no sooner than 1 clock after RELEASE.
- Timeout: a single counter (width ceil(log2(TIMEOUT+1))) covers WAIT_LOW+WAIT_HIGH and clears on grant. On reaching TIMEOUT: DONE[i] and TIMEOUT_ERR pulse together, then RELEASE.
- Pulses: WR and RD are never high together. At most one pulse per access; a pulse is never issued while GRANT!=0 from a previous access.
- REQ_EN dropping during an access does not abort it.

Optional Feature:
- Macro: SDRAM_SCHED_STARVE_GUARD_EN.
- Defined:
  - Each requester has an age counter, 0..STARVE_MAX, saturating.
  - The counter increments when the requester is pending and another requester is granted, and clears when it is granted or its pending bit clears.
  - In IDLE, any pending requester with age==STARVE_MAX wins over strict priority; ties go to the lowest index.
- Undefined: strict fixed priority, no age counters.

Test Plan:
- Single M68K: REQ[3] rises, ready=1, controller drops ready 2 clk after pulse and raises it 6 clk later → RD_PULSE at +2 with RD_TYPE=0, GRANT=4'b1000 for 10 clk, DONE[3] one cycle, BUSY then low.
- Simultaneous: REQ[3] and REQ[1] rise on the same clock → CROM served first (RD_TYPE=1, GRANT=0010), then M68K; two DONE strobes, in that order.
- Disabled: REQ[2] rises with REQ_EN[2]=0 → PENDING[2] clears with no RD_PULSE and no DONE. Then REQ_EN=1 and a new edge → served normally.
- Timeout: issue a CD write with ready held at 1 → WR_PULSE, then after 255 clk DONE[0] and TIMEOUT_ERR pulse together, GRANT clears.
- Reset mid-access: assert nRESET low during WAIT_HIGH → all outputs 0 immediately (asynchronous). Release reset, then a new REQ[0] edge → normal write.
- With SDRAM_SCHED_STARVE_GUARD_EN: REQ[3] pending while REQ[1] re-requests every access → REQ[3] is granted after exactly 4 CROM grants. Without the macro it waits until CROM stops requesting.
